// File: rtl/muldiv_sequencer.sv
// Sequences one multi-cycle mult/div through the external multdiv unit and
// commits its result to the regfile write port. Optional timeout: MULDIV_TIMEOUT_EN.
module muldiv_sequencer (
   input  logic        clock,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic        issue_op,
   input  logic [4:0]  issue_rd,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        unit_ready,
   input  logic [31:0] unit_result,
   input  logic        unit_exception,
   input  logic        mw_wren,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        ctrl_MULT,
   output logic        ctrl_DIV,
   output logic        stall,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic [4:0]  EXC_RD       = 5'd30;
   localparam logic [31:0] EXC_MULT_VAL = 32'd4;
   localparam logic [31:0] EXC_DIV_VAL  = 32'd5;
   localparam logic [5:0]  CNT_MAX      = 6'd63;
`ifdef MULDIV_TIMEOUT_EN
   localparam logic [5:0]  CNT_TIMEOUT  = 6'd39;
`endif

   state_e      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [4:0]  rd_q, rd_d;
   logic        op_q, op_d, exc_q, exc_d;

   logic        stall_c, ctrl_mult_c, ctrl_div_c, wb_valid_c;
   logic [4:0]  tgt_rd;
   logic [31:0] tgt_data;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         rd_q    <= '0;
         op_q    <= 1'b0;
         exc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         rd_q    <= rd_d;
         op_q    <= op_d;
         exc_q   <= exc_d;
      end
   end

   // An exception redirects the write to r30 with a fixed per-op code.
   assign tgt_rd   = exc_q ? EXC_RD : rd_q;
   assign tgt_data = exc_q ? (op_q ? EXC_DIV_VAL : EXC_MULT_VAL) : res_q;

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      rd_d        = rd_q;
      op_d        = op_q;
      exc_d       = exc_q;
      stall_c     = 1'b0;
      ctrl_mult_c = 1'b0;
      ctrl_div_c  = 1'b0;
      wb_valid_c  = 1'b0;

      unique case (state_q)
         IDLE: begin
            stall_c = issue_valid;
            if (issue_valid) begin
               a_d     = op_a;
               b_d     = op_b;
               op_d    = issue_op;
               rd_d    = issue_rd;
               exc_d   = 1'b0;
               state_d = START;
            end
         end
         START: begin
            stall_c     = 1'b1;
            ctrl_mult_c = ~op_q;
            ctrl_div_c  = op_q;
            cnt_d       = '0;
            state_d     = BUSY;
         end
         BUSY: begin
            stall_c = 1'b1;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;
            if (unit_ready) begin
               res_d   = unit_result;
               exc_d   = unit_exception;
               state_d = DONE;
            end
`ifdef MULDIV_TIMEOUT_EN
            else if (cnt_q == CNT_TIMEOUT) begin
               exc_d   = 1'b1;
               state_d = DONE;
            end
`endif
         end
         DONE: begin
            // MW owns the write port while mw_wren is high; commit on the first free cycle.
            stall_c = mw_wren;
            if (!mw_wren) begin
               wb_valid_c = (tgt_rd != 5'd0);
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All outputs are forced low while reset is held, whatever the current state.
   assign unit_a    = reset ? '0 : a_q;
   assign unit_b    = reset ? '0 : b_q;
   assign ctrl_MULT = ctrl_mult_c & ~reset;
   assign ctrl_DIV  = ctrl_div_c & ~reset;
   assign stall     = stall_c & ~reset;
   assign wb_valid  = wb_valid_c & ~reset;
   assign wb_rd     = (state_q == DONE && !mw_wren && !reset) ? tgt_rd : '0;
   assign wb_data   = (state_q == DONE && !mw_wren && !reset) ? tgt_data : '0;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports are named clock and reset.
REQ-002 The block SHALL have these ports:
- clock  in  1  master clock; all state updates on the rising edge
- reset  in  1  synchronous active-high reset
- issue_valid  in  1  DX holds a mult/div instruction
- issue_op  in  1  0 = mult, 1 = div
- issue_rd  in  5  destination register
- op_a  in  32  bypassed operand A
- op_b  in  32  bypassed operand B
- unit_ready  in  1  multdiv result-ready
- unit_result  in  32  multdiv result
- unit_exception  in  1  multdiv overflow / divide-by-zero
- mw_wren  in  1  MW stage owns the regfile write port this cycle
- unit_a  out  32  latched operand A to multdiv
- unit_b  out  32  latched operand B to multdiv
- ctrl_MULT  out  1  multdiv start pulse, multiply
- ctrl_DIV  out  1  multdiv start pulse, divide
- stall  out  1  freeze PC/FD/DX
- wb_valid  out  1  regfile write request, one cycle
- wb_rd  out  5  write register
- wb_data  out  32  write data

Function
REQ-003 The FSM SHALL have the states IDLE, START, BUSY and DONE, encoded in 2 bits.
REQ-004 In IDLE with issue_valid=1, the block SHALL latch op_a, op_b, issue_op and issue_rd, and go to START at the next edge.
REQ-005 stall SHALL equal issue_valid in IDLE, SHALL be 1 in START and BUSY, and SHALL be 1 in DONE except in the commit cycle.
REQ-006 In START, exactly one of ctrl_MULT/ctrl_DIV (per the latched op) SHALL be 1 for exactly one cycle; the FSM then goes to BUSY and the cycle counter clears to 0.
REQ-007 unit_ready SHALL be ignored in IDLE and START.
REQ-008 In BUSY, the 6-bit cycle counter SHALL increment each cycle; on unit_ready=1 the block SHALL capture unit_result and unit_exception and go to DONE.
REQ-009 unit_a and unit_b SHALL hold the latched operands from START until the next issue.
REQ-010 On a captured exception, the write SHALL target r30 with data 4 (mult) or 5 (div) instead of rd/result.
REQ-011 In DONE, the commit cycle SHALL be any cycle with mw_wren=0; MW has priority, so the block waits while mw_wren=1.
REQ-012 In the commit cycle the block SHALL assert wb_valid=1 with wb_rd/wb_data valid and stall=0, then return to IDLE at the edge.
REQ-013 wb_valid SHALL be suppressed when the target register is r0, but the commit still occurs.
REQ-014 issue_valid SHALL be accepted only in IDLE; the commit-cycle edge advances DX, so the same instruction is never re-issued.
REQ-015 wb_valid and the start pulses SHALL never be asserted in the same cycle.

Reset
REQ-016 reset SHALL force the FSM to IDLE, the counter to 0, and all latched data to 0.
REQ-017 During reset, every output SHALL be 0, including stall regardless of issue_valid.
REQ-018 A reset mid-operation SHALL abandon the operation, so a later unit_ready produces no writeback.

Configuration
REQ-019 With MULDIV_TIMEOUT_EN defined, when the BUSY counter reaches 40 without unit_ready, the block SHALL go to DONE with exception set.
REQ-020 Without MULDIV_TIMEOUT_EN, BUSY SHALL wait indefinitely, and the counter SHALL saturate at 63.

Verification
REQ-021 Mult 6*7, rd=5, unit_ready at BUSY cycle 32 with result 42 -> one ctrl_MULT pulse, then wb_valid, wb_rd=5, wb_data=42, stall low that cycle only.
REQ-022 Div 9/0, rd=3, unit_ready with exception=1 -> one ctrl_DIV pulse, then wb_rd=30, wb_data=5.
REQ-023 mw_wren=1 for the first 2 DONE cycles -> wb_valid on the 3rd DONE cycle, with stall=1 until then.
REQ-024 reset asserted in BUSY cycle 10, then unit_ready pulsed -> state IDLE, no wb_valid, stall=0.
REQ-025 MULDIV_TIMEOUT_EN defined with no unit_ready -> wb_rd=30 after 40 BUSY cycles; undefined -> stall stays 1 for 100 cycles.
REQ-026 Mult with rd=0, result 7 -> wb_valid stays 0, stall drops for one cycle, FSM returns to IDLE.
